// File: rtl/alu_seq_if.sv
// Handshake and result bus for alu_seq: operand/op request channel plus held result channel.
// The slave modport is the ALU side; the master modport is the source/consumer side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [3:0]             s;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     y;
    logic                   carry;
    logic                   zero;
    logic                   div0;

    modport slave (
        input  in_valid, a, b, s, out_ready,
        output in_ready, out_valid, y, carry, zero, div0
    );

    modport master (
        output in_valid, a, b, s, out_ready,
        input  in_ready, out_valid, y, carry, zero, div0
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/add/shift ops, iterative shift-add
// multiply and restoring divide; results are held with flags until accepted downstream.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    alu_seq_if.slave   ifc
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic [3:0] {
        OP_PASS, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
        OP_NOT, OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR, OP_CMP, OP_INC
    } op_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [2*WIDTH-1:0]   y_q, y_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 div0_q, div0_d;

    op_t                  op;
    logic                 in_ready;
    logic                 accept;

    logic [SW-1:0]        sh;
    logic [WIDTH:0]       add_sum, sub_diff, inc_sum;
    logic [WIDTH:0]       shl_ext, shr_ext, sar_ext;
    logic [WIDTH-1:0]     rol_res, ror_res;
    logic [WIDTH:0]       res;
    logic                 alu_c;
    logic [2*WIDTH-1:0]   alu_y;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_top, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step;

    assign op       = op_t'(ifc.s);
    assign sh       = ifc.b[SW-1:0];
    assign in_ready = en && (state_q == IDLE || (state_q == DONE && ifc.out_ready));
    assign accept   = ifc.in_valid && in_ready;

    // Rotates built bit-by-bit; index arithmetic wraps because WIDTH is a power of two.
    always_comb begin
        rol_res = '0;
        ror_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rol_res[i] = ifc.a[SW'(i) - sh];
            ror_res[i] = ifc.a[SW'(i) + sh];
        end
    end

    // NOTE: every variable written here gets a default first, so no latches are inferred.
    always_comb begin
        add_sum  = {1'b0, ifc.a} + {1'b0, ifc.b};
        sub_diff = {1'b0, ifc.a} - {1'b0, ifc.b};
        inc_sum  = {1'b0, ifc.a} + {{WIDTH{1'b0}}, 1'b1};
        shl_ext  = {1'b0, ifc.a} << sh;
        shr_ext  = {ifc.a, 1'b0} >> sh;
        sar_ext  = $signed({ifc.a, 1'b0}) >>> sh;
        res      = '0;
        alu_c    = 1'b0;
        unique case (op)
            OP_PASS: res = {1'b0, ifc.a};
            OP_ADD:  begin res = add_sum;  alu_c = add_sum[WIDTH]; end
            OP_SUB:  begin res = {1'b0, sub_diff[WIDTH-1:0]}; alu_c = sub_diff[WIDTH]; end
            OP_AND:  res = {1'b0, ifc.a & ifc.b};
            OP_OR:   res = {1'b0, ifc.a | ifc.b};
            OP_XOR:  res = {1'b0, ifc.a ^ ifc.b};
            OP_NOT:  res = {1'b0, ~ifc.a};
            OP_SHL:  begin res = {1'b0, shl_ext[WIDTH-1:0]}; alu_c = shl_ext[WIDTH]; end
            OP_SHR:  begin res = {1'b0, shr_ext[WIDTH:1]};   alu_c = shr_ext[0]; end
            OP_SAR:  begin res = {1'b0, sar_ext[WIDTH:1]};   alu_c = sar_ext[0]; end
            OP_ROL:  res = {1'b0, rol_res};
            OP_ROR:  res = {1'b0, ror_res};
            OP_CMP:  res = {{(WIDTH-2){1'b0}}, $signed(ifc.a) < $signed(ifc.b),
                            ifc.a < ifc.b, ifc.a == ifc.b};
            OP_INC:  begin res = inc_sum; alu_c = inc_sum[WIDTH]; end
            default: res = '0;
        endcase
        alu_y = {{(WIDTH-1){1'b0}}, res};
    end

    // One iteration step: shift-add multiply or restoring divide on the shared work register.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opd_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
        div_top  = work_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opd_q};
        if (div_top >= {1'b0, opd_q})
            div_next = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        else
            div_next = {div_top[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        step = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opd_d    = opd_q;
        work_d   = work_q;
        y_d      = y_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        div0_d   = div0_q;
        if (en) begin
            if (state_q == EXEC) begin
                work_d = step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d = DONE;
                    y_d     = step;
                    carry_d = 1'b0;
                    zero_d  = (step == '0);
                    div0_d  = 1'b0;
                end
            end else begin
                if (state_q == DONE && ifc.out_ready)
                    state_d = IDLE;
                if (accept) begin
                    cnt_d = '0;
                    if (op == OP_MUL) begin
                        state_d  = EXEC;
                        is_div_d = 1'b0;
                        opd_d    = ifc.a;
                        work_d   = {{WIDTH{1'b0}}, ifc.b};
                    end else if (op == OP_DIV && ifc.b != '0) begin
                        state_d  = EXEC;
                        is_div_d = 1'b1;
                        opd_d    = ifc.b;
                        work_d   = {{WIDTH{1'b0}}, ifc.a};
                    end else if (op == OP_DIV) begin
                        state_d = DONE;
                        y_d     = {ifc.a, {WIDTH{1'b1}}};
                        carry_d = 1'b0;
                        zero_d  = 1'b0;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        y_d     = alu_y;
                        carry_d = alu_c;
                        zero_d  = (alu_y == '0);
                        div0_d  = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opd_q    <= '0;
            work_q   <= '0;
            y_q      <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opd_q    <= opd_d;
            work_q   <= work_d;
            y_q      <= y_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            div0_q   <= div0_d;
        end
    end

    assign ifc.in_ready  = in_ready;
    assign ifc.out_valid = (state_q == DONE);
    assign ifc.y         = y_q;
    assign ifc.carry     = carry_q;
    assign ifc.zero      = zero_q;
    assign ifc.div0      = div0_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): reference model feeds a scoreboard queue,
// results are popped and compared as the ALU presents them.
module tb_alu_seq;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;

    alu_seq_if #(.WIDTH(W)) ifc ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .ifc   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*W-1:0] y;
        logic           carry;
        logic           zero;
        logic           div0;
    } res_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] s);
        res_t           r;
        int             sh;
        logic [2*W-1:0] t;
        r  = '0;
        sh = int'(b) % W;
        case (s)
            4'd0:  r.y = {8'h00, a};
            4'd1:  begin r.y = 16'(a) + 16'(b); r.carry = r.y[8]; end
            4'd2:  begin r.y = {8'h00, 8'(a - b)}; r.carry = (a < b); end
            4'd3:  r.y = 16'(a) * 16'(b);
            4'd4:  if (b == 0) begin r.y = {a, 8'hFF}; r.div0 = 1'b1; end
                   else r.y = {8'(a % b), 8'(a / b)};
            4'd5:  r.y = {8'h00, a & b};
            4'd6:  r.y = {8'h00, a | b};
            4'd7:  r.y = {8'h00, a ^ b};
            4'd8:  r.y = {8'h00, ~a};
            4'd9:  begin t = 16'(a) << sh; r.y = {8'h00, t[7:0]}; r.carry = t[8]; end
            4'd10: begin r.y = {8'h00, a >> sh}; r.carry = (sh == 0) ? 1'b0 : a[sh-1]; end
            4'd11: begin r.y = {8'h00, 8'($signed(a) >>> sh)};
                         r.carry = (sh == 0) ? 1'b0 : a[sh-1]; end
            4'd12: begin t = {a, a} << sh; r.y = {8'h00, t[15:8]}; end
            4'd13: begin t = {a, a} >> sh; r.y = {8'h00, t[7:0]}; end
            4'd14: r.y = {13'h0, $signed(a) < $signed(b), a < b, a == b};
            default: begin r.y = 16'(a) + 16'd1; r.carry = r.y[8]; end
        endcase
        r.zero = (r.y == 0);
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("y=%h c=%b z=%b d=%b", r.y, r.carry, r.zero, r.div0);
    endfunction

    function automatic res_t observed();
        res_t r;
        r.y     = ifc.y;
        r.carry = ifc.carry;
        r.zero  = ifc.zero;
        r.div0  = ifc.div0;
        return r;
    endfunction

    // Present an op at posedge+1, wait for the capturing edge, leave time at that edge +1.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
        int n = 0;
        ifc.a = a; ifc.b = b; ifc.s = s; ifc.in_valid = 1'b1;
        sb.push_back(model(a, b, s));
        while (!ifc.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, need 1", ifc.in_ready, n);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    // Count edges (capture edge = 1) until out_valid; also count cycles in_ready was high meanwhile.
    task automatic wait_out(input int start, output int lat, output int rdy_seen, output res_t got);
        lat = start;
        rdy_seen = 0;
        while (!ifc.out_valid && lat < 100) begin
            if (ifc.in_ready) rdy_seen++;
            @(posedge clk); #1;
            lat++;
        end
        got = observed();
    endtask

    task automatic consume();
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] s, input int exp_lat);
        int   lat, rdy;
        res_t got, exp;
        drive(a, b, s);
        wait_out(1, lat, rdy, got);
        exp = sb.pop_front();
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, need %0d", name, lat, exp_lat);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s result: got %s, need %s", name, fmt(got), fmt(exp));
        end
        if (exp_lat > 1) begin
            checks++;
            if (rdy !== 0) begin
                errors++;
                $display("FAIL %s busy: in_ready high %0d cycles during exec, need 0", name, rdy);
            end
        end
        consume();
    endtask

    task automatic test_reset();
        res_t got;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        ifc.a = '0; ifc.b = '0; ifc.s = '0;
        #1;
        got = observed();
        checks++;
        if (ifc.out_valid !== 1'b0 || got !== res_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b %s, need v=0 all zero", ifc.out_valid, fmt(got));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, need 1", ifc.in_ready);
        end
    endtask

    task automatic test_add_sub_xor();
        run_one("add_ee",  8'hEE, 8'hEE, 4'd1, 1);
        run_one("sub_5_7", 8'h05, 8'h07, 4'd2, 1);
        run_one("xor_ee",  8'hEE, 8'hEE, 4'd7, 1);
    endtask

    task automatic test_single_ops();
        run_one("shl_81_1",  8'h81, 8'h01, 4'd9,  1);
        run_one("shl_81_0",  8'h81, 8'h08, 4'd9,  1);
        run_one("shr_81_1",  8'h81, 8'h01, 4'd10, 1);
        run_one("sar_84_3",  8'h84, 8'h03, 4'd11, 1);
        run_one("rol_81_3",  8'h81, 8'h03, 4'd12, 1);
        run_one("ror_01_1",  8'h01, 8'h01, 4'd13, 1);
        run_one("cmp_80_01", 8'h80, 8'h01, 4'd14, 1);
        run_one("cmp_eq",    8'h3C, 8'h3C, 4'd14, 1);
        run_one("inc_ff",    8'hFF, 8'h00, 4'd15, 1);
        run_one("not_a5",    8'hA5, 8'h00, 4'd8,  1);
        run_one("pass_00",   8'h00, 8'h55, 4'd0,  1);
        run_one("and_f0",    8'hF3, 8'h3F, 4'd5,  1);
        run_one("or_0f",     8'h0A, 8'h50, 4'd6,  1);
    endtask

    task automatic test_mul_div();
        run_one("mul_ee",   8'hEE, 8'hEE, 4'd3, 9);
        run_one("mul_ff",   8'hFF, 8'hFF, 4'd3, 9);
        run_one("mul_zero", 8'h00, 8'h7B, 4'd3, 9);
        run_one("div_ee_5", 8'hEE, 8'h05, 4'd4, 9);
        run_one("div_ee_0", 8'hEE, 8'h00, 4'd4, 1);
        run_one("div_ff_1", 8'hFF, 8'h01, 4'd4, 9);
        run_one("div_03_9", 8'h03, 8'h09, 4'd4, 9);
    endtask

    task automatic test_hold();
        int   lat, rdy;
        res_t held, got, exp;
        drive(8'h05, 8'h03, 4'd1);
        wait_out(1, lat, rdy, held);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            got = observed();
            checks++;
            if (got !== held || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b r=%b %s, need v=1 r=0 %s",
                         i, ifc.out_valid, ifc.in_ready, fmt(got), fmt(held));
            end
        end
        exp = sb.pop_front();
        checks++;
        if (held !== exp) begin
            errors++;
            $display("FAIL hold_result: got %s, need %s", fmt(held), fmt(exp));
        end
        ifc.a = 8'h0F; ifc.b = 8'hF0; ifc.s = 4'd7; ifc.in_valid = 1'b1;
        sb.push_back(model(8'h0F, 8'hF0, 4'd7));
        ifc.out_ready = 1'b1;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b, need 1", ifc.in_ready);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        got = observed();
        exp = sb.pop_front();
        checks++;
        if (ifc.out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL release_same_cycle: got v=%b %s, need v=1 %s", ifc.out_valid, fmt(got), fmt(exp));
        end
        consume();
    endtask

    task automatic test_en_stall();
        int   lat, rdy;
        res_t got, exp;
        drive(8'h13, 8'h0B, 4'd3);
        repeat (2) begin @(posedge clk); #1; end
        en = 1'b0;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b, need 0", ifc.in_ready);
        end
        repeat (3) begin @(posedge clk); #1; end
        en = 1'b1;
        wait_out(6, lat, rdy, got);
        exp = sb.pop_front();
        checks++;
        if (lat !== 12) begin
            errors++;
            $display("FAIL stall_latency: got %0d edges, need 12", lat);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_result: got %s, need %s", fmt(got), fmt(exp));
        end
        consume();
    endtask

    task automatic test_reset_exec();
        res_t got;
        int   seen = 0;
        drive(8'hEE, 8'hEE, 4'd3);
        void'(sb.pop_back());
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (ifc.out_valid !== 1'b0 || got !== res_t'(0)) begin
            errors++;
            $display("FAIL abort_outputs: got v=%b %s, need v=0 all zero", ifc.out_valid, fmt(got));
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_ready: got %b, need 1", ifc.in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            if (ifc.out_valid) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid high %0d cycles, need 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        res_t       got, exp;
        logic [3:0] s;
        logic [W-1:0] a, b;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 4'($urandom_range(0, 13));
            if (s >= 4'd3) s = s + 4'd2;
            ifc.a = a; ifc.b = b; ifc.s = s; ifc.in_valid = 1'b1;
            sb.push_back(model(a, b, s));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            checks++;
            if (ifc.out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL b2b[%0d] s=%0d a=%h b=%h: got v=%b %s, need v=1 %s",
                         i, s, a, b, ifc.out_valid, fmt(got), fmt(exp));
            end
        end
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid got %b, need 0", ifc.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_sub_xor();
        test_single_ops();
        test_mul_div();
        test_hold();
        test_en_stall();
        test_reset_exec();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit ALU. It accepts one operation per transaction over a valid/ready interface. Logic and add ops complete in one cycle; multiply and divide run as iterative WIDTH-cycle sequences. Results are held with carry, zero and divide-by-zero flags until the downstream consumer accepts them. It sits between the operand/instruction source and the writeback stage of the datapath.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 4 and a power of two
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; 0 freezes all state, forces in_ready=0, holds outputs
- in_valid  input  1  operand/op valid
- in_ready  output  1  block can accept an op this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- s  input  4  operation select
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  2*WIDTH  result
- carry  output  1  carry/borrow/shift-out flag
- zero  output  1  y == 0
- div0  output  1  divide by zero occurred

## Operation
- Accept occurs when in_valid && in_ready && en. a, b and s are captured on accept.
- Op codes (s):
  - 0 PASS: y=a
  - 1 ADD: y={0,a+b} (WIDTH+1 bits); carry=sum[WIDTH]
  - 2 SUB: y=(a−b) mod 2^WIDTH, zero-extended; carry=borrow (a<b unsigned)
  - 3 MUL: unsigned a*b, full 2*WIDTH product
  - 4 DIV: unsigned; y={remainder, quotient}
  - 5 AND, 6 OR, 7 XOR, 8 NOT a: WIDTH result, zero-extended
  - 9 SHL, 10 SHR (logical), 11 SAR: shift a by b[log2(WIDTH)-1:0]; carry=last bit shifted out (0 for shift 0)
  - 12 ROL, 13 ROR: rotate a by b[log2(WIDTH)-1:0]
  - 14 CMP: y[0]=(a==b), y[1]=(a<b unsigned), y[2]=(a<b signed), other bits 0
  - 15 INC: y={0,a+1}; carry=bit WIDTH
- carry=0 for any op not listed above as setting it. zero=(y==0) for every op. div0=0 except DIV with b=0.
- DIV with b=0: no iteration is run. y={a, all-ones}, div0=1, carry=0. The result is ready one cycle after accept.
- MUL is iterative shift-add, one bit per cycle over WIDTH cycles. DIV is restoring division, one quotient bit per cycle over WIDTH cycles.
- FSM states:
  - IDLE: accept → EXEC (ops 3/4 with b≠0 for DIV) or DONE (all other ops)
  - EXEC: count WIDTH cycles, then DONE
  - DONE: out_valid=1; out_ready → IDLE, or accept a new op in the same cycle
- in_ready = en && (state==IDLE || (state==DONE && out_ready)).
- In DONE with out_ready=0: y, carry, zero, div0 and out_valid stay stable.

## Timing
- Reset (async assert, any state):
  - state=IDLE, out_valid=0, y=0, carry=0, zero=0, div0=0, iteration counter=0
  - in_ready=1 on the first clock edge after deassert, if en=1
- Reset asserted during EXEC aborts the operation. No result is produced.
- Single-cycle ops: out_valid rises on the edge following accept (latency 1).
- MUL and DIV (b≠0): out_valid rises WIDTH+1 edges after accept, i.e. 9 for WIDTH=8.
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the new op is accepted in the same cycle.
  - Single-cycle ops sustain one result per cycle under continuous out_ready.
- Outputs update only on clk edges. y and flags change only on entry to DONE.
- en=0 during EXEC stalls the iteration counter and datapath. The result is unchanged once en returns.
- Simultaneous en=0 and in_valid: no accept occurs.

## Test plan
- Reset, WIDTH=8, a=b=0xEE, s=1 accepted → 1 cycle later out_valid=1, y=0x01DC, carry=1, zero=0.
- a=0x05, b=0x07, s=2 → y=0x00FE, carry=1; then a=b=0xEE, s=7 → y=0x0000, zero=1.
- a=b=0xEE, s=3 → in_ready=0 for 8 cycles, out_valid exactly 9 edges after accept, y=0xDD44.
- a=0xEE, b=0x05, s=4 → y=0x032F after 9 edges. Then b=0x00, s=4 → y=0xEEFF, div0=1, after 1 edge.
- Hold out_ready=0 for 5 cycles in DONE → y and flags stable, in_ready=0. Release with in_valid=1 → new op accepted in the same cycle.
- Start MUL, pulse en=0 for 3 cycles mid-EXEC → latency becomes 12, y still correct. Start another MUL and assert rst_n=0 mid-EXEC → out_valid=0, y=0 immediately, in_ready=1 after release.
